// File: rtl/char_mem_sequencer.sv
// Owns the single port of the character memory: arbitrates single-character
// writes against bulk clear/scroll operations and drives the memory port.
module char_mem_sequencer #(
  parameter int unsigned COLS      = 64,
  parameter int unsigned ROWS      = 16,
  parameter logic [7:0]  FILL_CHAR = 8'h20,
  localparam int unsigned XW = $clog2(COLS),
  localparam int unsigned YW = $clog2(ROWS),
  localparam int unsigned AW = XW + YW
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  output logic          wr_ready,
  input  logic          cmd_valid,
  input  logic [1:0]    cmd_op,
  input  logic [XW-1:0] cmd_x,
  input  logic [YW-1:0] cmd_y,
  output logic          cmd_ready,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          mem_wen,
  input  logic [7:0]    mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    SCR_RD,
    SCR_WR
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = '1;
  localparam logic [AW-1:0] SCR_LAST  = AW'((ROWS - 1) * COLS - 1);
  localparam logic [AW-1:0] ROW_STEP  = AW'(COLS);

  state_t        state;
  logic [AW-1:0] counter;
  logic [AW-1:0] end_addr;
  logic [AW-1:0] cmd_start;
  logic [AW-1:0] cmd_end;

  assign wr_ready  = (state == IDLE);
  assign cmd_ready = (state == IDLE) && !wr_req;

  always_comb begin
    cmd_start = '0;
    cmd_end   = LAST_ADDR;
    case (cmd_op)
      2'd1: begin
        cmd_start = {cmd_y, cmd_x};
        cmd_end   = {cmd_y, {XW{1'b1}}};
      end
      2'd2: cmd_start = {cmd_y, cmd_x};
      default: ;
    endcase
  end

  // Outputs are loaded on the edge that enters a state, so each state's
  // memory access is visible during the cycle the FSM sits in it.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= IDLE;
      counter   <= '0;
      end_addr  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wen   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          mem_wen <= 1'b0;
          if (wr_req) begin
            mem_addr  <= wr_addr;
            mem_wdata <= wr_data;
            mem_wen   <= 1'b1;
          end else if (cmd_valid) begin
            busy <= 1'b1;
            if (cmd_op == 2'd3) begin
              counter  <= '0;
              mem_addr <= ROW_STEP;
              state    <= SCR_RD;
            end else begin
              counter   <= cmd_start;
              end_addr  <= cmd_end;
              mem_addr  <= cmd_start;
              mem_wdata <= FILL_CHAR;
              mem_wen   <= 1'b1;
              state     <= FILL;
            end
          end
        end
        FILL: begin
          // Equality stop keeps an end of the last address from wrapping to 0.
          if (counter == end_addr) begin
            mem_wen <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
          end else begin
            counter  <= counter + 1'b1;
            mem_addr <= counter + 1'b1;
          end
        end
        SCR_RD: begin
          mem_addr  <= counter;
          mem_wdata <= mem_rdata;
          mem_wen   <= 1'b1;
          state     <= SCR_WR;
        end
        SCR_WR: begin
          counter <= counter + 1'b1;
          if (counter == SCR_LAST) begin
            end_addr  <= LAST_ADDR;
            mem_addr  <= counter + 1'b1;
            mem_wdata <= FILL_CHAR;
            state     <= FILL;
          end else begin
            mem_addr <= counter + ROW_STEP + 1'b1;
            mem_wen  <= 1'b0;
            state    <= SCR_RD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_char_mem_sequencer.sv
// Self-checking bench for char_mem_sequencer: behavioural 64x16 memory model,
// write log and per-scenario tasks compared against a screen-level reference.
module tb_char_mem_sequencer;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       wr_req;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [5:0] cmd_x;
  logic [3:0] cmd_y;
  logic       cmd_ready;
  logic       busy;
  logic       done;
  logic [9:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_wen;
  logic [7:0] mem_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] mem     [1024];
  logic [7:0] pre_img [1024];
  logic       load_req = 1'b0;
  logic [9:0] wlog_a [$];
  logic [7:0] wlog_d [$];
  int         done_cnt = 0;

  char_mem_sequencer #(
    .COLS(64),
    .ROWS(16),
    .FILL_CHAR(8'h20)
  ) dut (
    .clk(clk),
    .clr_n(clr_n),
    .wr_req(wr_req),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_ready(wr_ready),
    .cmd_valid(cmd_valid),
    .cmd_op(cmd_op),
    .cmd_x(cmd_x),
    .cmd_y(cmd_y),
    .cmd_ready(cmd_ready),
    .busy(busy),
    .done(done),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wen(mem_wen),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Character memory: combinational read, sampled by the DUT at the next edge.
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pre_img[i];
    end else if (mem_wen) begin
      mem[mem_addr] <= mem_wdata;
      wlog_a.push_back(mem_addr);
      wlog_d.push_back(mem_wdata);
    end
  end

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic preload(input bit pattern);
    for (int i = 0; i < 1024; i++)
      pre_img[i] = pattern ? 8'(8'h41 + i / 64) : 8'($urandom);
    @(negedge clk) load_req = 1'b1;
    @(negedge clk) load_req = 1'b0;
  endtask

  task automatic wait_cmd_ready(input string name);
    bit got = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin
        got = 1;
        break;
      end
    end
    n_chk++;
    if (!got) $display("FAIL %s_ready: cmd_ready never rose, required 1", name);
    else n_pass++;
  endtask

  // Runs one bulk command and checks timing, write order and final screen.
  task automatic run_cmd(input logic [1:0] op, input int unsigned x,
                         input int unsigned y, input string name);
    logic [7:0] exp_mem [1024];
    int unsigned s, e, n_exp, wl0, busy_n, bad;
    bit got;
    for (int i = 0; i < 1024; i++) exp_mem[i] = mem[i];
    if (op == 2'd3) begin
      for (int a = 0; a < 1024; a++) exp_mem[a] = (a < 960) ? mem[a + 64] : 8'h20;
      s = 0; e = 1023; n_exp = 1984;
    end else begin
      s = (op == 2'd0) ? 0 : y * 64 + x;
      e = (op == 2'd1) ? y * 64 + 63 : 1023;
      for (int a = int'(s); a <= int'(e); a++) exp_mem[a] = 8'h20;
      n_exp = e - s + 1;
    end
    wait_cmd_ready(name);
    wl0 = wlog_a.size();
    cmd_valid = 1'b1; cmd_op = op; cmd_x = 6'(x); cmd_y = 4'(y);
    @(negedge clk);
    cmd_valid = 1'b0;
    busy_n = 0; got = 0;
    for (int k = 0; k < 3000; k++) begin
      if (done === 1'b1) begin
        got = 1;
        break;
      end
      if (busy === 1'b1) busy_n++;
      cmd_op = 2'($urandom); cmd_x = 6'($urandom); cmd_y = 4'($urandom);
      @(negedge clk);
    end
    n_chk++;
    if (!got) $display("FAIL %s_done: done never pulsed within 3000 cycles", name);
    else n_pass++;
    n_chk++;
    if (busy_n != n_exp) $display("FAIL %s_cycles: busy cycles %0d, required %0d", name, busy_n, n_exp);
    else n_pass++;
    n_chk++;
    if ({busy, wr_ready} !== 2'b01)
      $display("FAIL %s_done_cycle: busy,wr_ready=%b, required 01", name, {busy, wr_ready});
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0) $display("FAIL %s_pulse: done=%b one cycle later, required 0", name, done);
    else n_pass++;
    repeat (2) @(negedge clk);
    bad = 0;
    if (wlog_a.size() - wl0 != e - s + 1) bad++;
    else
      for (int i = 0; i < int'(e - s + 1); i++)
        if (wlog_a[wl0 + i] !== 10'(s + i) || wlog_d[wl0 + i] !== exp_mem[s + i]) bad++;
    n_chk++;
    if (bad != 0)
      $display("FAIL %s_writes: %0d writes logged with %0d bad entries, required %0d writes %0d..%0d",
               name, wlog_a.size() - wl0, bad, e - s + 1, s, e);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== exp_mem[i]) bad++;
    n_chk++;
    if (bad != 0) $display("FAIL %s_screen: %0d cells differ, required 0", name, bad);
    else n_pass++;
  endtask

  task automatic test_reset;
    clr_n = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_x = '0; cmd_y = '0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({mem_wen, busy, done} !== 3'b000)
      $display("FAIL reset_flags: wen,busy,done=%b, required 000", {mem_wen, busy, done});
    else n_pass++;
    n_chk++;
    if ({mem_addr, mem_wdata} !== 18'h0)
      $display("FAIL reset_port: addr=%0h wdata=%0h, required 0 0", mem_addr, mem_wdata);
    else n_pass++;
    clr_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({wr_ready, cmd_ready, mem_wen} !== 3'b110)
      $display("FAIL reset_idle: wr_ready,cmd_ready,wen=%b, required 110", {wr_ready, cmd_ready, mem_wen});
    else n_pass++;
  endtask

  task automatic test_clear;
    preload(0);
    run_cmd(2'd0, $urandom_range(63, 0), $urandom_range(15, 0), "clr_screen");
    preload(0);
    run_cmd(2'd1, 60, 3, "eol_60_3");
    run_cmd(2'd1, 63, 15, "eol_63_15");
    run_cmd(2'd2, 0, 15, "eos_0_15");
    run_cmd(2'd2, 63, 15, "eos_63_15");
    for (int i = 0; i < 4; i++) begin
      preload(0);
      run_cmd(2'(1 + (i % 2)), $urandom_range(63, 0), $urandom_range(15, 0), "rand_clr");
    end
  endtask

  task automatic test_scroll;
    int bad = 0;
    preload(1);
    run_cmd(2'd3, $urandom_range(63, 0), $urandom_range(15, 0), "scroll");
    for (int a = 0; a < 1024; a++)
      if (mem[a] !== ((a < 960) ? 8'(8'h42 + a / 64) : 8'h20)) bad++;
    n_chk++;
    if (bad != 0) $display("FAIL scroll_rows: %0d cells off the row pattern, required 0", bad);
    else n_pass++;
  endtask

  task automatic test_arbitration;
    logic [9:0] wa = 10'($urandom);
    logic [7:0] wd = 8'($urandom);
    int unsigned y = $urandom_range(15, 0);
    int wl0;
    wait_cmd_ready("arb");
    wl0 = wlog_a.size();
    wr_req = 1'b1; wr_addr = wa; wr_data = wd;
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_x = 6'd62; cmd_y = 4'(y);
    #1;
    n_chk++;
    if ({wr_ready, cmd_ready} !== 2'b10)
      $display("FAIL arb_ready: wr_ready,cmd_ready=%b, required 10", {wr_ready, cmd_ready});
    else n_pass++;
    @(negedge clk);
    wr_req = 1'b0;
    n_chk++;
    if ({mem_wen, mem_addr, mem_wdata} !== {1'b1, wa, wd} || busy !== 1'b0)
      $display("FAIL arb_single: wen=%b addr=%0h data=%0h busy=%b, required 1 %0h %0h 0",
               mem_wen, mem_addr, mem_wdata, busy, wa, wd);
    else n_pass++;
    @(negedge clk);
    cmd_valid = 1'b0;
    n_chk++;
    if ({busy, mem_wen, mem_addr} !== {2'b11, 10'(y * 64 + 62)})
      $display("FAIL arb_cmd: busy=%b wen=%b addr=%0h, required 1 1 %0h", busy, mem_wen, mem_addr, y * 64 + 62);
    else n_pass++;
    repeat (4) @(negedge clk);
    n_chk++;
    if (wlog_a.size() - wl0 != 3 || wlog_a[wl0] !== wa || wlog_a[wl0 + 2] !== 10'(y * 64 + 63))
      $display("FAIL arb_order: %0d writes logged, required 3 (single then fill)", wlog_a.size() - wl0);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [9:0] wa [8];
    logic [7:0] wd [8];
    int bad = 0;
    int wl0;
    wait_cmd_ready("b2b");
    wl0 = wlog_a.size();
    for (int i = 0; i < 8; i++) begin
      wa[i] = 10'($urandom); wd[i] = 8'($urandom);
      wr_req = 1'b1; wr_addr = wa[i]; wr_data = wd[i];
      #1 if (wr_ready !== 1'b1) bad++;
      @(negedge clk);
    end
    wr_req = 1'b0;
    repeat (2) @(negedge clk);
    if (wlog_a.size() - wl0 != 8) bad++;
    else for (int i = 0; i < 8; i++) if (wlog_a[wl0 + i] !== wa[i] || wlog_d[wl0 + i] !== wd[i]) bad++;
    n_chk++;
    if (bad != 0) $display("FAIL b2b_writes: %0d bad, %0d logged, required 0 bad and 8 logged", bad, wlog_a.size() - wl0);
    else n_pass++;
  endtask

  task automatic test_wr_during_scroll;
    logic [9:0] wa = 10'($urandom);
    logic [7:0] wd = 8'($urandom);
    int leak = 0;
    int bad = 0;
    bit got = 0;
    preload(1);
    wait_cmd_ready("hold");
    cmd_valid = 1'b1; cmd_op = 2'd3;
    repeat (10) @(negedge clk);
    cmd_valid = 1'b0;
    wr_req = 1'b1; wr_addr = wa; wr_data = wd;
    for (int k = 0; k < 3000; k++) begin
      if (wr_ready === 1'b1) begin
        got = 1;
        break;
      end
      if (busy !== 1'b1) leak++;
      @(negedge clk);
    end
    n_chk++;
    if (!got || leak != 0 || done !== 1'b1)
      $display("FAIL hold_ready: got=%0d non-busy stall cycles=%0d done=%b, required 1 0 1", got, leak, done);
    else n_pass++;
    @(negedge clk);
    wr_req = 1'b0;
    n_chk++;
    if ({mem_wen, mem_addr, mem_wdata} !== {1'b1, wa, wd})
      $display("FAIL hold_write: wen=%b addr=%0h data=%0h, required 1 %0h %0h", mem_wen, mem_addr, mem_wdata, wa, wd);
    else n_pass++;
    @(negedge clk);
    for (int a = 0; a < 1024; a++)
      if (mem[a] !== ((a == int'(wa)) ? wd : (a < 960) ? 8'(8'h42 + a / 64) : 8'h20)) bad++;
    n_chk++;
    if (bad != 0) $display("FAIL hold_screen: %0d cells differ, required 0", bad);
    else n_pass++;
  endtask

  task automatic test_reset_mid_scroll;
    int wl, dn;
    preload(0);
    wait_cmd_ready("rst");
    cmd_valid = 1'b1; cmd_op = 2'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (499) @(negedge clk);
    n_chk++;
    if ({busy, mem_wen} !== 2'b11) $display("FAIL rst_pre: busy,wen=%b at cycle 500, required 11", {busy, mem_wen});
    else n_pass++;
    #2 clr_n = 1'b0;
    #1;
    n_chk++;
    if ({mem_wen, busy, done, mem_addr} !== 13'h0)
      $display("FAIL rst_async: wen=%b busy=%b done=%b addr=%0h, required all 0", mem_wen, busy, done, mem_addr);
    else n_pass++;
    wl = wlog_a.size();
    dn = done_cnt;
    repeat (3) @(negedge clk);
    clr_n = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (wlog_a.size() != wl || done_cnt != dn)
      $display("FAIL rst_quiet: %0d writes, %0d done pulses after reset, required 0 0", wlog_a.size() - wl, done_cnt - dn);
    else n_pass++;
    run_cmd(2'd0, 0, 0, "rst_clear");
  endtask

  initial begin
    test_reset();
    test_clear();
    test_scroll();
    test_arbitration();
    test_back_to_back();
    test_wr_during_scroll();
    test_reset_mid_scroll();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/char_mem_sequencer.md
Name: char_mem_sequencer

Overview:
- Owns the single write/read port of the 64x16 character memory.
- Arbitrates between single-character writes from the command handler and multi-cycle bulk operations: clear screen, clear to end of line, clear to end of screen, and scroll up one line.
- Sits between the command handler and the char buffer. Upstream is stalled while a bulk operation runs.

Parameters:
- COLS, 64, characters per row; must be a power of two.
- ROWS, 16, rows per screen; must be a power of two.
- FILL_CHAR, 8'h20, code written by clear and scroll fill.

Ports:
- clk  input  1  system clock; only clock.
- clr_n  input  1  asynchronous active-low reset.
- wr_req  input  1  single-char write request from the command handler.
- wr_addr  input  10  address {y[3:0],x[5:0]} of the single write.
- wr_data  input  8  char code of the single write.
- wr_ready  output  1  single write is accepted in this cycle.
- cmd_valid  input  1  bulk operation request.
- cmd_op  input  2  0=clear screen, 1=clear to EOL, 2=clear to EOS, 3=scroll up.
- cmd_x  input  6  cursor column, sampled on accept.
- cmd_y  input  4  cursor row, sampled on accept.
- cmd_ready  output  1  bulk operation accepted in this cycle.
- busy  output  1  a bulk operation is in progress.
- done  output  1  one-cycle pulse when a bulk operation completes.
- mem_addr  output  10  char memory address.
- mem_wdata  output  8  char memory write data.
- mem_wen  output  1  char memory write enable.
- mem_rdata  input  8  char memory read data, valid one cycle after mem_addr is presented with mem_wen=0.

Behaviour:
- Reset (clr_n low, asynchronous):
  - State goes to IDLE.
  - mem_addr=0, mem_wdata=0, mem_wen=0, busy=0, done=0.
  - Any operation in progress is abandoned; no further writes are issued.
  - Partial memory contents are left as they are.
- Reset deassertion is not required to be synchronised by this block.
- All mem_* outputs are registered.
- States: IDLE, FILL, SCR_RD, SCR_WR.
- wr_ready = (state==IDLE). It is combinational.
- cmd_ready = (state==IDLE) && !wr_req. A pending single write wins over a simultaneous bulk command; the command is accepted in the first IDLE cycle with wr_req low.
- IDLE, wr_req=1: next cycle mem_addr=wr_addr, mem_wdata=wr_data, mem_wen=1 for exactly one cycle. Back-to-back single writes are allowed every cycle.
- IDLE, command accepted:
  - Latch the start address S and end address E (inclusive).
  - Set busy=1 from the next cycle.
  - S and E per op:
    - op0: S=0, E=1023.
    - op1: S={cmd_y,cmd_x}, E={cmd_y,6'd63}.
    - op2: S={cmd_y,cmd_x}, E=1023.
    - op3: counter=0; go to SCR_RD.
- FILL:
  - Each cycle: mem_addr=counter, mem_wdata=FILL_CHAR, mem_wen=1.
  - If counter==E, go to IDLE; otherwise counter+1.
  - Termination is by equality compare, never by counter overflow (E=1023 must not wrap to 0).
- SCR_RD: mem_addr=counter+64, mem_wen=0; go to SCR_WR.
- SCR_WR:
  - mem_addr=counter, mem_wdata=mem_rdata, mem_wen=1.
  - If counter==959: S=960, E=1023, go to FILL.
  - Otherwise counter+1 and go to SCR_RD.
- Cycle counts from accept to done:
  - Scroll: 960*2 + 64 = 1984 memory cycles.
  - Clear screen: 1024 cycles.
  - Clear EOL: 64-x cycles.
  - Clear EOS: 1024-{y,x} cycles.
- done: pulses 1 in the first IDLE cycle after the final write cycle. busy falls in that same cycle, and cmd_ready/wr_ready may be 1 in it.
- While busy:
  - wr_ready=0 and cmd_ready=0.
  - Requesters hold their requests (valid/ready handshake).
  - cmd_x, cmd_y and cmd_op are ignored after accept.
- Cursor-position-independent ops (op0, op3) ignore cmd_x and cmd_y.
- Boundary cases:
  - cmd_x=63 with op1: exactly one write.
  - {15,63} with op2: exactly one write, to 1023.

Test Plan:
- Clear screen: op0 accepted at cycle T -> mem_wen high at T+1..T+1024; addresses 0..1023 in order; data 0x20; done at T+1025; no write to 0 after 1023.
- Clear EOL: op1 with x=60, y=3 -> exactly 4 writes, addresses 252..255, then done; op1 with x=63 -> single write to 1023 for y=15.
- Clear EOS: op2 with x=0, y=15 -> 64 writes, 960..1023. Scroll: preload memory model with row r filled with 0x41+r, issue op3 -> row r holds 0x42+r for r=0..14, row 15 is all 0x20, done after 1984 memory cycles.
- Arbitration: wr_req and cmd_valid both high in IDLE -> single write issued first, command accepted the following cycle. wr_req held during a scroll -> wr_ready=0 until done, then the write lands.
- Reset mid-scroll: assert clr_n low at memory cycle 500 -> mem_wen=0 immediately (asynchronously); busy=0, done never pulses. After release, op0 runs normally from address 0.
